// File: rtl/emu_time_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : emu_time_sched_pkg
// Brief    : Shared types, state encodings and dt clipping helper for the
//            emulation time scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package emu_time_sched_pkg;

    // Scheduler state encodings (visible on the sched_state port)
    localparam logic [1:0] ST_PAUSED  = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        PAUSED  = ST_PAUSED,
        RUNNING = ST_RUNNING,
        STEP    = ST_STEP,
        DONE    = ST_DONE
    } sched_state_t;

    // Working width of the clip helper; callers zero-extend into it, so
    // TIME_WIDTH must not exceed this value.
    localparam int CLIP_W = 64;

    // Limit a requested timestep to the time remaining before the stop point.
    function automatic logic [CLIP_W-1:0] dt_clip(input logic [CLIP_W-1:0] dt,
                                                  input logic [CLIP_W-1:0] rem);
        return (dt < rem) ? dt : rem;
    endfunction

endpackage
`default_nettype wire

// File: rtl/emu_time_sched_dt_min_tree.sv
`default_nettype none
// ============================================================================
// Module   : dt_min_tree
// Brief    : Combinational balanced minimum reduction over N_REQ packed dt
//            requests. Unused leaves of the padded tree hold all-ones so they
//            never win the compare.
// Revision : 1.0 - initial release
// ============================================================================
module dt_min_tree #(
    parameter int N_REQ    = 2,
    parameter int DT_WIDTH = 27
) (
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    output logic [DT_WIDTH-1:0]       dt_min
);

    localparam int LEVELS = (N_REQ > 1) ? $clog2(N_REQ) : 0;
    localparam int NPAD   = 1 << LEVELS;

    logic [DT_WIDTH-1:0] leaf [NPAD];
    logic [DT_WIDTH-1:0] lvl  [NPAD];

    // Unpack requests into tree leaves, padding up to a power of two
    for (genvar i = 0; i < NPAD; i++) begin : g_leaf
        if (i < N_REQ) begin : g_real
            assign leaf[i] = dt_req[i*DT_WIDTH +: DT_WIDTH];
        end else begin : g_pad
            assign leaf[i] = '1;
        end
    end

    // Pairwise reduction level by level; each pass halves the live width
    always_comb begin
        for (int i = 0; i < NPAD; i++) begin
            lvl[i] = leaf[i];
        end
        for (int w = NPAD / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                lvl[i] = (lvl[2*i] < lvl[2*i+1]) ? lvl[2*i] : lvl[2*i+1];
            end
        end
        dt_min = lvl[0];
    end

endmodule
`default_nettype wire

// File: rtl/emu_time_sched.sv
`default_nettype none
// ============================================================================
// Module   : emu_time_sched
// Brief    : Emulation time scheduler. Selects the global timestep as the
//            minimum of all requester dt values, clipped to the time left
//            before stop_time, and integrates it into emu_time. A small FSM
//            sequences run / pause / single-step / stop-at-time.
// Options  : EMU_TIME_SCHED_STALL_CNT_EN - adds the 32-bit saturating
//            stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module emu_time_sched
    import emu_time_sched_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DT_WIDTH   = 27,
    parameter int TIME_WIDTH = 39
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic                      ctrl_run,
    input  logic                      ctrl_step,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      emu_stall,
    output logic [1:0]                sched_state,
    output logic                      sched_done
`ifdef EMU_TIME_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    sched_state_t          state;
    sched_state_t          next_state;
    logic [DT_WIDTH-1:0]   dt_min;
    logic [DT_WIDTH-1:0]   dt_cand;
    logic [TIME_WIDTH-1:0] rem;
    logic                  reach_stop;
    logic                  active;

    dt_min_tree #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH)
    ) u_dt_min_tree (
        .dt_req (dt_req),
        .dt_min (dt_min)
    );

    // Timestep datapath: remaining time, clipped candidate and gated output.
    // reach_stop compares against rem so a stop_time already behind emu_time
    // (rem saturated to 0) also counts as having arrived.
    always_comb begin
        rem        = (stop_time > emu_time) ? (stop_time - emu_time) : '0;
        dt_cand    = DT_WIDTH'(dt_clip(CLIP_W'(dt_min), CLIP_W'(rem)));
        reach_stop = (TIME_WIDTH'(dt_cand) == rem);
        active     = (state == RUNNING) || (state == STEP);
        emu_dt     = active ? dt_cand : '0;
        emu_stall  = (emu_dt == '0);
        sched_done = (state == DONE);
    end

    assign sched_state = state;

    // FSM state register
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state <= PAUSED;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; run beats step, stop-reached beats pause
    always_comb begin
        next_state = state;
        case (state)
            PAUSED: begin
                if (ctrl_run || ctrl_step) begin
                    if (rem == '0) begin
                        next_state = DONE;
                    end else if (ctrl_run) begin
                        next_state = RUNNING;
                    end else begin
                        next_state = STEP;
                    end
                end
            end
            RUNNING: begin
                if (reach_stop) begin
                    next_state = DONE;
                end else if (!ctrl_run) begin
                    next_state = PAUSED;
                end
            end
            STEP: begin
                next_state = reach_stop ? DONE : PAUSED;
            end
            DONE: begin
                if ((stop_time > emu_time) && ctrl_run) begin
                    next_state = RUNNING;
                end
            end
            default: next_state = PAUSED;
        endcase
    end

    // Time integrator; the rem clip keeps emu_time from passing stop_time
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            emu_time <= '0;
        end else begin
            emu_time <= emu_time + TIME_WIDTH'(emu_dt);
        end
    end

`ifdef EMU_TIME_SCHED_STALL_CNT_EN
    // Saturating count of stalled cycles while time is meant to advance
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            stall_cnt <= '0;
        end else if (active && emu_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_emu_time_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_time_sched
// Brief    : Scoreboard bench for emu_time_sched. Each stimulus cycle pushes
//            its expected outputs; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_time_sched;

    localparam int NR  = 2;
    localparam int DTW = 27;
    localparam int TW  = 39;

    localparam int SP = 0;
    localparam int SR = 1;
    localparam int SS = 2;
    localparam int SD = 3;

    typedef struct {
        logic [DTW-1:0] dt;
        logic [TW-1:0]  t;
        logic [1:0]     st;
        logic [31:0]    cnt;
    } exp_t;

    logic              emu_clk = 1'b0;
    logic              emu_rst;
    logic [NR*DTW-1:0] dt_req;
    logic              ctrl_run;
    logic              ctrl_step;
    logic [TW-1:0]     stop_time;
    logic [DTW-1:0]    emu_dt;
    logic [TW-1:0]     emu_time;
    logic              emu_stall;
    logic [1:0]        sched_state;
    logic              sched_done;
`ifdef EMU_TIME_SCHED_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    exp_t sb[$];
    exp_t m;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   exp_cnt = 0;

    always #5 emu_clk = ~emu_clk;

    emu_time_sched #(
        .N_REQ      (NR),
        .DT_WIDTH   (DTW),
        .TIME_WIDTH (TW)
    ) dut (
        .emu_clk     (emu_clk),
        .emu_rst     (emu_rst),
        .dt_req      (dt_req),
        .ctrl_run    (ctrl_run),
        .ctrl_step   (ctrl_step),
        .stop_time   (stop_time),
        .emu_dt      (emu_dt),
        .emu_time    (emu_time),
        .emu_stall   (emu_stall),
        .sched_state (sched_state),
        .sched_done  (sched_done)
`ifdef EMU_TIME_SCHED_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // One cycle of stimulus plus the outputs expected during that cycle
    task automatic cyc(input bit rst, input bit run, input bit step,
                       input int stop, input int r1, input int r0,
                       input int e_dt, input int e_t, input int e_st);
        exp_t e;
        emu_rst   = rst;
        ctrl_run  = run;
        ctrl_step = step;
        stop_time = TW'(stop);
        dt_req    = {DTW'(r1), DTW'(r0)};
        e.dt  = DTW'(e_dt);
        e.t   = TW'(e_t);
        e.st  = 2'(e_st);
        e.cnt = 32'(exp_cnt);
        sb.push_back(e);
        if (rst) begin
            exp_cnt = 0;
        end else if ((e_st == SR || e_st == SS) && e_dt == 0) begin
            exp_cnt = exp_cnt + 1;
        end
        @(posedge emu_clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    always @(negedge emu_clk) begin
        if (sb.size() != 0) begin
            m = sb.pop_front();
            n_vec++;
            if (emu_dt !== m.dt) begin
                n_miss++;
                $display("FAIL emu_dt vec %0d: got %0d expected %0d", n_vec, emu_dt, m.dt);
            end
            if (emu_time !== m.t) begin
                n_miss++;
                $display("FAIL emu_time vec %0d: got %0d expected %0d", n_vec, emu_time, m.t);
            end
            if (sched_state !== m.st) begin
                n_miss++;
                $display("FAIL sched_state vec %0d: got %0d expected %0d", n_vec, sched_state, m.st);
            end
            if (emu_stall !== (m.dt == '0)) begin
                n_miss++;
                $display("FAIL emu_stall vec %0d: got %0b expected %0b", n_vec, emu_stall, (m.dt == '0));
            end
            if (sched_done !== (m.st == 2'd3)) begin
                n_miss++;
                $display("FAIL sched_done vec %0d: got %0b expected %0b", n_vec, sched_done, (m.st == 2'd3));
            end
`ifdef EMU_TIME_SCHED_STALL_CNT_EN
            if (stall_cnt !== m.cnt) begin
                n_miss++;
                $display("FAIL stall_cnt vec %0d: got %0d expected %0d", n_vec, stall_cnt, m.cnt);
            end
`endif
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        emu_rst   = 1'b1;
        ctrl_run  = 1'b0;
        ctrl_step = 1'b0;
        stop_time = '0;
        dt_req    = '0;
        @(posedge emu_clk);
        #1;

        // Reset state
        cyc(1, 0, 0, 1000, 100, 40, 0, 0, SP);

        // Free-run to stop at 1000 with dt=40
        cyc(0, 1, 0, 1000, 100, 40, 0, 0, SP);
        for (int k = 0; k < 25; k++) begin
            cyc(0, 1, 0, 1000, 100, 40, 40, 40 * k, SR);
        end
        cyc(0, 1, 0, 1000, 100, 40, 0, 1000, SD);

        // DONE: lowered stop holds; raised stop resumes
        cyc(0, 1, 0, 800, 100, 40, 0, 1000, SD);
        cyc(0, 1, 0, 800, 100, 40, 0, 1000, SD);
        cyc(0, 1, 0, 1500, 100, 40, 0, 1000, SD);
        cyc(0, 1, 0, 1500, 100, 40, 40, 1000, SR);
        cyc(0, 1, 0, 1500, 100, 40, 40, 1040, SR);
        cyc(0, 0, 0, 1500, 100, 40, 40, 1080, SR);
        cyc(0, 0, 0, 1500, 100, 40, 0, 1120, SP);

        // Reset, then clipped final step: 30,30,30,10 to stop at 100
        cyc(1, 0, 0, 1500, 100, 40, 0, 1120, SP);
        cyc(0, 1, 0, 100, 30, 70, 0, 0, SP);
        cyc(0, 1, 0, 100, 30, 70, 30, 0, SR);
        cyc(0, 1, 0, 100, 30, 70, 30, 30, SR);
        cyc(0, 1, 0, 100, 30, 70, 30, 60, SR);
        cyc(0, 1, 0, 100, 30, 70, 10, 90, SR);
        cyc(0, 1, 0, 100, 30, 70, 0, 100, SD);
        cyc(0, 0, 0, 100, 30, 70, 0, 100, SD);

        // Reset, run to 50 and pause
        cyc(1, 0, 0, 100, 30, 70, 0, 100, SD);
        cyc(0, 1, 0, 1000, 25, 25, 0, 0, SP);
        cyc(0, 1, 0, 1000, 25, 25, 25, 0, SR);
        cyc(0, 0, 0, 1000, 25, 25, 25, 25, SR);

        // Single step with a second pulse during STEP that must be ignored
        cyc(0, 0, 1, 1000, 5, 9, 0, 50, SP);
        cyc(0, 0, 1, 1000, 5, 9, 5, 50, SS);
        cyc(0, 0, 0, 1000, 5, 9, 0, 55, SP);
        cyc(0, 0, 0, 1000, 5, 9, 0, 55, SP);

        // run and step together: run wins
        cyc(0, 1, 1, 1000, 5, 9, 0, 55, SP);
        cyc(0, 1, 0, 1000, 5, 9, 5, 55, SR);

        // Requester 1 stalls time for 4 cycles
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 1000, 0, 9, 0, 60, SR);
        end
        cyc(0, 1, 0, 1000, 5, 9, 5, 60, SR);
        cyc(0, 0, 0, 1000, 5, 9, 5, 65, SR);
        cyc(0, 0, 0, 1000, 5, 9, 0, 70, SP);

        // Reset, run to 600, then reset mid-run with run still high
        cyc(1, 0, 0, 1000, 5, 9, 0, 70, SP);
        cyc(0, 1, 0, 1000, 100, 40, 0, 0, SP);
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1, 0, 1000, 100, 40, 40, 40 * k, SR);
        end
        cyc(1, 1, 0, 1000, 100, 40, 40, 600, SR);
        cyc(0, 0, 0, 1000, 100, 40, 0, 0, SP);
        cyc(0, 0, 0, 1000, 100, 40, 0, 0, SP);

        #6;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/emu_time_sched.md
Name: emu_time_sched

Overview:
- Emulation time scheduler. Each emu_clk cycle it picks the timestep emu_dt as the minimum of N_REQ requester dt requests.
- Integrates emu_dt into the global emulated time emu_time, using fixed-point integer ticks.
- Sequences the time datapath through run, pause, single-step and stop-at-time.
- Sits at the emulator top level, feeding emu_dt and emu_time to every analog block and to the probe/trace logic.

Parameters:
- N_REQ, 2, number of dt requesters (1..16).
- DT_WIDTH, 27, unsigned width of each dt request and of emu_dt, in ticks.
- TIME_WIDTH, 39, unsigned width of emu_time, in ticks; must be >= DT_WIDTH+1.

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst  in  1  reset, synchronous, active-high.
- dt_req  in  N_REQ*DT_WIDTH  packed requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- ctrl_run  in  1  level; 1 = free-run, 0 = pause.
- ctrl_step  in  1  one-cycle pulse; advance exactly one timestep while paused.
- stop_time  in  TIME_WIDTH  absolute stop time in ticks; sampled each cycle.
- emu_dt  out  DT_WIDTH  timestep applied in the current cycle (combinational).
- emu_time  out  TIME_WIDTH  registered emulated time.
- emu_stall  out  1  1 when emu_dt==0 this cycle.
- sched_state  out  2  encoded FSM state.
- sched_done  out  1  1 in state DONE.

Behaviour:
- Reset (synchronous, active-high, on emu_clk): state=PAUSED, emu_time=0. emu_dt=0, emu_stall=1 and sched_done=0 follow combinationally.
- States: PAUSED=0, RUNNING=1, STEP=2, DONE=3.
- dt_min = unsigned minimum over all dt_req[i]. Ties have no priority effect.
- Remaining time: rem = stop_time - emu_time, computed at TIME_WIDTH; rem saturates to 0 if stop_time < emu_time.
- dt_cand = min(dt_min, rem), zero-extended for the compare.
- emu_dt = dt_cand in RUNNING or STEP; emu_dt = 0 in PAUSED or DONE.
- emu_time <= emu_time + emu_dt every cycle. There is no wrap: the rem clip guarantees emu_time <= stop_time.
- Latency: emu_dt is valid in the same cycle as dt_req. Its effect on emu_time is visible the next cycle.
- PAUSED transitions:
  - to RUNNING if ctrl_run=1;
  - else to STEP if ctrl_step=1;
  - ctrl_run has priority over ctrl_step when both are asserted.
- RUNNING transitions:
  - to DONE if emu_time+emu_dt == stop_time (next time reaches stop);
  - else to PAUSED if ctrl_run=0;
  - the DONE check has priority.
- STEP: applies exactly one emu_dt. Next state is DONE if stop is reached, else PAUSED. ctrl_step pulses arriving during STEP are ignored.
- DONE: holds time, emu_dt=0. Leaves DONE only when stop_time > emu_time and ctrl_run=1 (to RUNNING). Otherwise it stays.
- Entering from PAUSED with emu_time already == stop_time: go to DONE, apply no step.
- Any dt_req[i]=0 in RUNNING gives emu_dt=0 and emu_stall=1. State stays RUNNING (a requester may stall time indefinitely).
- emu_rst asserted mid-run wins over all inputs in that cycle.

Optional Feature:
- Macro: EMU_TIME_SCHED_STALL_CNT_EN.
- Defined:
  - adds output stall_cnt, 32 bits;
  - counts cycles with emu_stall=1 while state is RUNNING or STEP;
  - saturates at 2^32-1;
  - cleared by emu_rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package emu_time_sched_pkg holds:
  - enum sched_state_t (PAUSED, RUNNING, STEP, DONE), 2 bits;
  - localparams for the state encodings;
  - function dt_clip(dt, rem).
- Sub-module dt_min_tree (params N_REQ, DT_WIDTH): combinational balanced minimum reduction of dt_req. Instantiated once.

Test Plan:
- Reset, then ctrl_run=1 with dt_req={100,40} and stop_time=1000 → emu_dt=40 each cycle; emu_time=0,40,...,960. Final step clipped to emu_dt=40 → emu_time=1000, DONE, emu_stall=1.
- ctrl_run=1 with dt_req={30,70} and stop_time=100 → steps 30,30,30,10; sched_done asserts on the cycle emu_time=100.
- Paused at emu_time=50, dt_req={5,9}: ctrl_step pulse → exactly one increment to 55, back to PAUSED. Second pulse during STEP ignored. Then ctrl_run and ctrl_step together → RUNNING.
- RUNNING with dt_req[1] forced to 0 for 4 cycles → emu_dt=0 and emu_time frozen for 4 cycles, state stays RUNNING. With EMU_TIME_SCHED_STALL_CNT_EN, stall_cnt increments by 4.
- In DONE at 1000: stop_time raised to 1500 with ctrl_run=1 → RUNNING, resumes stepping. stop_time lowered to 800 → stays DONE, emu_time unchanged.
- emu_rst pulsed at emu_time=600 mid-run → next cycle emu_time=0, state=PAUSED, emu_dt=0.
